// File: rtl/punc_seq_ctrl.sv
// punc_seq_ctrl: multi-cycle control sequencer for the PUnC LC3 datapath.
// Walks each instruction through IDLE, FETCH, DECODE, EXEC1 and optionally
// EXEC2. It counts memory wait states, supports free-run and single-step,
// traps on illegal opcodes, and exposes retire and state observation outputs.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | between instructions; waits for run_en or a step token
// FETCH  | instruction read, MEM_LAT cycles; IR load and PC+1 on last
// DECODE | one cycle; opcode chooses EXEC1 or HALT
// EXEC1  | single-cycle ops, or the first memory access of LD/ST class
// EXEC2  | second (indirect) access of LDI/STI, MEM_LAT cycles
// HALT   | TRAP or illegal opcode; only rst leaves
//
// Ports:
//   clk, rst (sync, active-high)
//   run_en, step   run control
//   ir, nzp        instruction register and condition codes from datapath
//   mem_*, mdr_ld, ir_ld, pc_*, rf_*, alu_op, cc_ld   datapath strobes
//   retire, halted, illegal, state_o                  observation
module punc_seq_ctrl #(
  parameter int MEM_LAT     = 1,
  parameter bit LEA_SETS_CC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        step,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_addr_sel,
  output logic        mdr_ld,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic        rf_dst_r7,
  output logic [1:0]  alu_op,
  output logic        cc_ld,
  output logic        retire,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state_o
);

  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(MEM_LAT - 1);

  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_JSR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_RTI = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_STI = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_RSV = 4'hD;
  localparam logic [3:0] OP_LEA = 4'hE;
  localparam logic [3:0] OP_TRP = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          step_tok_q, step_tok_d;
  logic          illegal_q, illegal_d;

  logic [3:0] op;
  logic       last;
  logic       br_taken;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign last      = (wcnt_q == W_LAST);
  assign br_taken  = |(ir[11:9] & nzp);
  assign unused_ir = ^ir[8:0];

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    // A step pulse always arms the token, except on the cycle the token is
    // consumed, where the pulse is dropped.
    step_tok_d = step_tok_q | step;
    case (state_q)
      S_IDLE: begin
        if (run_en || step_tok_q) begin
          state_d    = S_FETCH;
          step_tok_d = 1'b0;
        end
      end
      S_FETCH: if (last) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_TRP) begin
          state_d = S_HALT;
        end else if (op == OP_RTI || op == OP_RSV) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC1;
        end
      end
      S_EXEC1: begin
        case (op)
          OP_LD, OP_LDR, OP_ST, OP_STR: if (last) state_d = S_IDLE;
          OP_LDI, OP_STI:               if (last) state_d = S_EXEC2;
          default:                      state_d = S_IDLE;
        endcase
      end
      S_EXEC2: if (last) state_d = S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Only memory states dwell, and they leave on the last count, so the
    // increment never wraps.
    if (state_d == state_q && state_q != S_IDLE && state_q != S_HALT)
      wcnt_d = wcnt_q + WW'(1);
    else
      wcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      step_tok_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      step_tok_q <= step_tok_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr_sel = 2'd0;
    mdr_ld       = 1'b0;
    ir_ld        = 1'b0;
    pc_inc       = 1'b0;
    pc_ld        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    rf_wsel      = 2'd0;
    rf_dst_r7    = 1'b0;
    alu_op       = 2'd3;
    cc_ld        = 1'b0;
    retire       = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = last;
        pc_inc = last;
      end
      S_EXEC1: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_we  = 1'b1;
            cc_ld  = 1'b1;
            retire = 1'b1;
            alu_op = (op == OP_ADD) ? 2'd0 : (op == OP_AND) ? 2'd1 : 2'd2;
          end
          OP_LEA: begin
            rf_we   = 1'b1;
            rf_wsel = 2'd2;
            cc_ld   = LEA_SETS_CC;
            retire  = 1'b1;
          end
          OP_BR: begin
            pc_ld  = br_taken;
            retire = 1'b1;
          end
          OP_JMP: begin
            pc_ld  = 1'b1;
            pc_sel = 2'd2;
            retire = 1'b1;
          end
          OP_JSR: begin
            rf_we     = 1'b1;
            rf_wsel   = 2'd3;
            rf_dst_r7 = 1'b1;
            pc_ld     = 1'b1;
            pc_sel    = ir[11] ? 2'd1 : 2'd2;
            retire    = 1'b1;
          end
          OP_LD, OP_LDR: begin
            mem_rd       = 1'b1;
            mem_addr_sel = (op == OP_LD) ? 2'd1 : 2'd2;
            rf_we        = last;
            rf_wsel      = last ? 2'd1 : 2'd0;
            cc_ld        = last;
            retire       = last;
          end
          OP_ST, OP_STR: begin
            mem_wr       = 1'b1;
            mem_addr_sel = (op == OP_ST) ? 2'd1 : 2'd2;
            retire       = last;
          end
          OP_LDI, OP_STI: begin
            mem_rd       = 1'b1;
            mem_addr_sel = 2'd1;
            mdr_ld       = last;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        mem_addr_sel = 2'd3;
        if (op == OP_LDI) begin
          mem_rd  = 1'b1;
          rf_we   = last;
          rf_wsel = last ? 2'd1 : 2'd0;
          cc_ld   = last;
        end else begin
          mem_wr = 1'b1;
        end
        retire = last;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_punc_seq_ctrl.sv
// tb_punc_seq_ctrl: builds the expected per-cycle output trace of each
// instruction from its phase list (IDLE, FETCH, DECODE, EXEC1, EXEC2, HALT)
// and compares every cycle against punc_seq_ctrl.
module tb_punc_seq_ctrl;

  localparam int L      = 3;
  localparam bit LEA_CC = 1'b1;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] asel;
    logic       mdr_ld;
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic       dst7;
    logic [1:0] alu;
    logic       cc_ld;
    logic       retire;
    logic       halted;
    logic       illegal;
  } ov_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_en = 1'b0;
  logic        step = 1'b0;
  logic [15:0] ir = 16'h0;
  logic [2:0]  nzp = 3'b0;

  logic       mem_rd, mem_wr, mdr_ld, ir_ld, pc_inc, pc_ld;
  logic       rf_we, rf_dst_r7, cc_ld, retire, halted, illegal;
  logic [1:0] mem_addr_sel, pc_sel, rf_wsel, alu_op;
  logic [2:0] state_o;

  ov_t obs;
  ov_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  rd_cnt;

  always #5 clk = ~clk;

  punc_seq_ctrl #(.MEM_LAT(L), .LEA_SETS_CC(LEA_CC)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .step(step), .ir(ir), .nzp(nzp),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr_sel(mem_addr_sel),
    .mdr_ld(mdr_ld), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .pc_sel(pc_sel), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_dst_r7(rf_dst_r7),
    .alu_op(alu_op), .cc_ld(cc_ld), .retire(retire), .halted(halted),
    .illegal(illegal), .state_o(state_o)
  );

  assign obs = {state_o, mem_rd, mem_wr, mem_addr_sel, mdr_ld, ir_ld, pc_inc,
                pc_ld, pc_sel, rf_we, rf_wsel, rf_dst_r7, alu_op, cc_ld,
                retire, halted, illegal};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ov_t dflt(input logic [2:0] st);
    ov_t e;
    e     = '0;
    e.alu = 2'd3;
    e.st  = st;
    return e;
  endfunction

  task automatic build_exp(input logic [15:0] ir_v, input logic [2:0] nzp_v,
                           input int n_idle);
    ov_t e;
    logic [3:0] op;
    op = ir_v[15:12];
    exp_q.delete();
    for (int k = 0; k < n_idle; k++) exp_q.push_back(dflt(3'd0));
    for (int k = 0; k < L; k++) begin
      e = dflt(3'd1);
      e.mem_rd = 1'b1;
      if (k == L - 1) begin e.ir_ld = 1'b1; e.pc_inc = 1'b1; end
      exp_q.push_back(e);
    end
    exp_q.push_back(dflt(3'd2));
    if (op == 4'hF || op == 4'h8 || op == 4'hD) begin
      for (int k = 0; k < 4; k++) begin
        e = dflt(3'd5);
        e.halted  = 1'b1;
        e.illegal = (op != 4'hF);
        exp_q.push_back(e);
      end
      return;
    end
    e = dflt(3'd3);
    case (op)
      4'h1, 4'h5, 4'h9: begin
        e.rf_we = 1; e.cc_ld = 1; e.retire = 1;
        e.alu = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
        exp_q.push_back(e);
      end
      4'hE: begin
        e.rf_we = 1; e.rf_wsel = 2; e.cc_ld = LEA_CC; e.retire = 1;
        exp_q.push_back(e);
      end
      4'h0: begin
        e.pc_ld = ((ir_v[11:9] & nzp_v) != 3'b000); e.retire = 1;
        exp_q.push_back(e);
      end
      4'hC: begin
        e.pc_ld = 1; e.pc_sel = 2; e.retire = 1;
        exp_q.push_back(e);
      end
      4'h4: begin
        e.rf_we = 1; e.rf_wsel = 3; e.dst7 = 1; e.pc_ld = 1;
        e.pc_sel = ir_v[11] ? 2'd1 : 2'd2; e.retire = 1;
        exp_q.push_back(e);
      end
      4'h2, 4'h6, 4'h3, 4'h7: begin
        for (int k = 0; k < L; k++) begin
          e = dflt(3'd3);
          e.asel = (op == 4'h2 || op == 4'h3) ? 2'd1 : 2'd2;
          if (op == 4'h2 || op == 4'h6) begin
            e.mem_rd = 1;
            if (k == L - 1) begin e.rf_we = 1; e.rf_wsel = 1; e.cc_ld = 1; end
          end else begin
            e.mem_wr = 1;
          end
          e.retire = (k == L - 1);
          exp_q.push_back(e);
        end
      end
      default: begin // LDI / STI
        for (int k = 0; k < L; k++) begin
          e = dflt(3'd3);
          e.mem_rd = 1; e.asel = 1; e.mdr_ld = (k == L - 1);
          exp_q.push_back(e);
        end
        for (int k = 0; k < L; k++) begin
          e = dflt(3'd4);
          e.asel = 3;
          if (op == 4'hA) begin
            e.mem_rd = 1;
            if (k == L - 1) begin e.rf_we = 1; e.rf_wsel = 1; e.cc_ld = 1; end
          end else begin
            e.mem_wr = 1;
          end
          e.retire = (k == L - 1);
          exp_q.push_back(e);
        end
      end
    endcase
  endtask

  // Called at posedge+1 with the DUT in IDLE; ends at posedge+1 after the
  // last compared cycle.
  task automatic run_instr(input string name, input logic [15:0] ir_v,
                           input logic [2:0] nzp_v, input int n_idle,
                           input int step_at, input int limit);
    ir  = ir_v;
    nzp = nzp_v;
    build_exp(ir_v, nzp_v, n_idle);
    rd_cnt = 0;
    #1;
    for (int i = 0; i < exp_q.size() && i < limit; i++) begin
      check($sformatf("%s[%0d]", name, i), 32'(obs), 32'(exp_q[i]));
      if (mem_rd) rd_cnt++;
      if (i == step_at) step = 1'b1;
      @(posedge clk);
      #1;
      step = 1'b0;
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", name, i), 32'(obs), 32'(dflt(3'd0)));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check(name, 32'(obs), 32'(dflt(3'd0)));
    rst = 1'b0;
  endtask

  task automatic halt_hold(input string name, input logic ill);
    ov_t h;
    h = dflt(3'd5);
    h.halted  = 1'b1;
    h.illegal = ill;
    ir = 16'h1042;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("%s[%0d]", name, i), 32'(obs), 32'(h));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  op;

    run_en = 1'b1;
    do_reset("reset");

    run_instr("add", 16'h1042, 3'b000, 1, -1, 99);
    run_instr("ldi", 16'hA005, 3'b001, 1, -1, 99);
    check("ldi_rd_cycles", rd_cnt, 3 * L);
    run_instr("sti", 16'hB1F0, 3'b010, 1, -1, 99);
    run_instr("br_nt", 16'h0A02, 3'b010, 1, -1, 99);
    run_instr("br_t", 16'h0A02, 3'b100, 1, -1, 99);
    run_instr("jsr", 16'h4801, 3'b010, 1, -1, 99);
    run_instr("jsrr", 16'h4080, 3'b010, 1, -1, 99);
    run_instr("lea", 16'hE3FF, 3'b010, 1, -1, 99);

    for (int n = 0; n < 40; n++) begin
      r  = $urandom;
      op = r[15:12];
      if (op == 4'h8 || op == 4'hD || op == 4'hF) op = 4'h1;
      run_instr($sformatf("rnd%0d", n), {op, r[11:0]}, 3'($urandom_range(0, 7)),
                1, -1, 99);
    end

    // Abort an ST in its second EXEC1 cycle.
    run_instr("st_abort", 16'h3000, 3'b001, 1, -1, L + 3);
    check("st_c2_mem_wr", mem_wr, 1'b1);
    do_reset("st_abort_rst");

    // Single-step: idle while disarmed, one instruction per pulse.
    run_en = 1'b0;
    idle_cycles("no_run", 20);
    run_instr("step_add", 16'h5042, 3'b000, 2, 0, 99);
    idle_cycles("after_step", 8);

    // Step on the IDLE exit cycle is dropped.
    run_en = 1'b1;
    run_instr("drop_step", 16'h9000, 3'b000, 1, 0, 99);
    run_en = 1'b0;
    idle_cycles("after_drop", 5);

    // Step during free-run leaves a token for the next IDLE exit.
    run_en = 1'b1;
    run_instr("tok_set", 16'h6000, 3'b000, 1, 2, 99);
    run_en = 1'b0;
    run_instr("tok_use", 16'h7000, 3'b000, 1, -1, 99);
    idle_cycles("after_tok", 5);

    run_en = 1'b1;
    run_instr("rsv", 16'hD000, 3'b000, 1, -1, 99);
    halt_hold("rsv_hold", 1'b1);
    do_reset("rsv_rst");
    run_instr("rti", 16'h8000, 3'b000, 1, -1, 99);
    do_reset("rti_rst");
    run_instr("trap", 16'hF025, 3'b000, 1, -1, 99);
    halt_hold("trap_hold", 1'b0);
    do_reset("trap_rst");
    run_instr("post_rst", 16'hC1C0, 3'b000, 1, -1, 99);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
